eeg_frame_buffer: RTL and testbench

//  Upstream feeder for the bit-serial distributed-arithmetic DCT stage.

---
 rtl/eeg_frame_buffer.sv | 195 +++++++++++++++++++
 tb/tb_eeg_frame_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eeg_frame_buffer.sv
// ---------------------------------------------------------------------------
// eeg_frame_buffer
//
// Feeds the bit-serial distributed-arithmetic DCT stage. Signed EEG samples
// arrive one per clock and are collected into 8-sample frames in a ping-pong
// (two-bank) buffer. Each completed frame is presented as eight parallel
// words that stay stable for one SERIAL_CYCLES-long DCT window. A one-cycle
// dct_load marks the start of every window.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   s_valid    in   input sample valid
//   s_ready    out  buffer can accept a sample (0 while rst is high)
//   s_data     in   signed input sample, DATA_W bits
//   dct_hold   in   downstream stall; blocks launching a new window
//   dct_load   out  one-cycle pulse: out0..out7 newly valid, window starts
//   dct_busy   out  high during every cycle of an active window
//   out0..out7 out  frame words, out0 = earliest sample of the frame
//   frame_cnt  out  number of frames launched, wraps at 2^CNT_W
// ---------------------------------------------------------------------------
module eeg_frame_buffer #(
  parameter int DATA_W        = 8,
  parameter int FRAME_LEN     = 8,
  parameter int SERIAL_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              dct_hold,
  output logic              dct_load,
  output logic              dct_busy,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [DATA_W-1:0] out4,
  output logic [DATA_W-1:0] out5,
  output logic [DATA_W-1:0] out6,
  output logic [DATA_W-1:0] out7,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int PTR_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int WIN_W = (SERIAL_CYCLES > 1) ? $clog2(SERIAL_CYCLES) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Two frame banks; written one word per accepted sample.
  logic [DATA_W-1:0] bank_mem [2][FRAME_LEN];

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic              wr_bank_reg;
  logic              rd_bank_reg;
  logic [1:0]        full_reg;
  logic [1:0]        full_next;
  state_t            state_reg;
  state_t            state_next;
  logic [WIN_W-1:0]  win_cnt_reg;
  logic [DATA_W-1:0] out_reg [FRAME_LEN];
  logic              dct_load_reg;
  logic              dct_busy_reg;
  logic [CNT_W-1:0]  frame_cnt_reg;

  logic accept;
  logic frame_done;
  logic launch;
  logic release_bank;
  logic launch_bank;

  // ---------------- write side ----------------
  assign s_ready    = !rst && !full_reg[wr_bank_reg];
  assign accept     = s_valid && s_ready;
  assign frame_done = accept && (wr_ptr_reg == PTR_W'(FRAME_LEN - 1));

  always_ff @(posedge clk) begin
    if (accept) begin
      bank_mem[wr_bank_reg][wr_ptr_reg] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      wr_bank_reg <= 1'b0;
    end else if (accept) begin
      if (frame_done) begin
        wr_ptr_reg  <= '0;
        wr_bank_reg <= ~wr_bank_reg;
      end else begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
    end
  end

  // ---------------- read FSM ----------------
  // On the last cycle of a window the current bank is released and, when
  // allowed, the other bank is launched on the same edge so dct_busy never
  // drops between back-to-back frames.
  always_comb begin
    state_next   = state_reg;
    launch       = 1'b0;
    release_bank = 1'b0;
    launch_bank  = rd_bank_reg;
    case (state_reg)
      IDLE: begin
        if (full_reg[rd_bank_reg] && !dct_hold) begin
          launch     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (win_cnt_reg == WIN_W'(SERIAL_CYCLES - 1)) begin
          release_bank = 1'b1;
          launch_bank  = ~rd_bank_reg;
          if (full_reg[~rd_bank_reg] && !dct_hold) begin
            launch = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
    endcase
  end

  // The write side sets the bank being filled, the read side clears the bank
  // being drained; these are always different banks so both apply together.
  always_comb begin
    full_next = full_reg;
    if (release_bank) begin
      full_next[rd_bank_reg] = 1'b0;
    end
    if (frame_done) begin
      full_next[wr_bank_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      full_reg      <= 2'b00;
      rd_bank_reg   <= 1'b0;
      win_cnt_reg   <= '0;
      dct_load_reg  <= 1'b0;
      dct_busy_reg  <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      full_reg     <= full_next;
      dct_load_reg <= launch;
      dct_busy_reg <= (state_next == BUSY);
      if (release_bank) begin
        rd_bank_reg <= ~rd_bank_reg;
      end
      if (launch) begin
        win_cnt_reg   <= '0;
        frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
      end else if (state_reg == BUSY) begin
        win_cnt_reg <= win_cnt_reg + WIN_W'(1);
      end
    end
  end

  // Output words only change on a launch edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        out_reg[i] <= '0;
      end
    end else if (launch) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        out_reg[i] <= bank_mem[launch_bank][i];
      end
    end
  end

  assign dct_load  = dct_load_reg;
  assign dct_busy  = dct_busy_reg;
  assign frame_cnt = frame_cnt_reg;
  assign out0      = out_reg[0];
  assign out1      = out_reg[1];
  assign out2      = out_reg[2];
  assign out3      = out_reg[3];
  assign out4      = out_reg[4];
  assign out5      = out_reg[5];
  assign out6      = out_reg[6];
  assign out7      = out_reg[7];

endmodule

// File: tb/tb_eeg_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_eeg_frame_buffer
//
// Scoreboard bench for eeg_frame_buffer. The driver side turns accepted
// samples into expected frames (queue of packed 8-word frames) and tracks
// buffer occupancy and window timing; a separate monitor pops a frame on
// every dct_load and compares the parallel outputs and frame counters.
// A second instance with a 3-bit frame counter exercises counter wrap.
// ---------------------------------------------------------------------------
module tb_eeg_frame_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       dct_hold = 1'b0;

  logic       s_ready, dct_load, dct_busy;
  logic [7:0] o [8];
  logic [15:0] frame_cnt;

  logic       s_ready_w, dct_load_w, dct_busy_w;
  logic [7:0] ow [8];
  logic [2:0] frame_cnt_w;

  always #5 clk = ~clk;

  eeg_frame_buffer dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .dct_hold(dct_hold), .dct_load(dct_load), .dct_busy(dct_busy),
    .out0(o[0]), .out1(o[1]), .out2(o[2]), .out3(o[3]),
    .out4(o[4]), .out5(o[5]), .out6(o[6]), .out7(o[7]),
    .frame_cnt(frame_cnt)
  );

  eeg_frame_buffer #(.CNT_W(3)) dut_w (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_w), .s_data(s_data),
    .dct_hold(dct_hold), .dct_load(dct_load_w), .dct_busy(dct_busy_w),
    .out0(ow[0]), .out1(ow[1]), .out2(ow[2]), .out3(ow[3]),
    .out4(ow[4]), .out5(ow[5]), .out6(ow[6]), .out7(ow[7]),
    .frame_cnt(frame_cnt_w)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model state ----------------
  logic [63:0] exp_q [$];     // expected frames, word i at bits [8*i +: 8]
  logic [7:0]  partial [$];   // accepted samples of the frame being filled
  int          buffered  = 0; // frames held in the buffer (incl. the one being read)
  int          countdown = 0; // cycles left in the current window
  bit          pending   = 0; // frame completed at the coming edge
  bit          exp_load  = 0;
  bit          obs_rst_prev = 0;
  int          hold_mode = 0; // 0: low, 1: high, 2: random

  // Driver-side observer: sample accounting, window timing, readiness.
  always @(negedge clk) begin
    if (rst) begin
      chk("ready_in_reset", s_ready, 0);
      if (obs_rst_prev) begin
        chk("load_in_reset", dct_load, 0);
        chk("busy_in_reset", dct_busy, 0);
      end
      buffered  = 0;
      countdown = 0;
      pending   = 0;
      exp_load  = 0;
      partial.delete();
      exp_q.delete();
    end else begin
      if (pending) begin
        buffered++;
        pending = 0;
      end
      chk("dct_load", dct_load, exp_load);
      chk("dct_load_w", dct_load_w, exp_load);
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) buffered--;
      end
      if (dct_load) countdown = 8;
      chk("dct_busy", dct_busy, countdown > 0);
      chk("dct_busy_w", dct_busy_w, countdown > 0);
      chk("s_ready", s_ready, buffered < 2);
      chk("s_ready_w", s_ready_w, buffered < 2);
      // A window launches at the next edge when hold is low and a full bank
      // is waiting, either from idle or on the last cycle of a window.
      exp_load = !dct_hold && ((countdown == 0 && buffered >= 1) ||
                               (countdown == 1 && buffered >= 2));
      if (s_valid && s_ready) begin
        partial.push_back(s_data);
        if (partial.size() == 8) begin
          logic [63:0] f;
          for (int i = 0; i < 8; i++) f[8*i +: 8] = partial[i];
          exp_q.push_back(f);
          partial.delete();
          pending = 1;
        end
      end
    end
    obs_rst_prev = rst;
  end

  // Monitor: frame contents and counters.
  int          launched = 0;
  logic [63:0] last_frame = '0;
  bit          mon_rst_prev = 0;

  always @(negedge clk) begin
    logic [63:0] got, got_w, f;
    for (int i = 0; i < 8; i++) begin
      got[8*i +: 8]   = o[i];
      got_w[8*i +: 8] = ow[i];
    end
    if (rst) begin
      if (mon_rst_prev) begin
        chk("out_in_reset", got, 64'h0);
        chk("frame_cnt_in_reset", frame_cnt, 0);
      end
      launched   = 0;
      last_frame = '0;
    end else if (dct_load) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_load", 1, 0);
      end else begin
        f = exp_q.pop_front();
        launched++;
        $display("frame %0d: out=%h expected=%h cnt=%0d", launched, got, f, frame_cnt);
        chk("frame_data", got, f);
        chk("frame_data_w", got_w, f);
        chk("frame_cnt", frame_cnt, launched % 65536);
        chk("frame_cnt_wrap", frame_cnt_w, launched % 8);
        last_frame = f;
      end
    end else begin
      chk("out_hold", got, last_frame);
    end
    mon_rst_prev = rst;
  end

  // Single driver of dct_hold.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (hold_mode)
        0:       dct_hold = 1'b0;
        1:       dct_hold = 1'b1;
        default: dct_hold = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] d);
    int w;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    w = 0;
    while (!s_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] t2 [8];
    int w;
    t2[0] = 8'd1;   t2[1] = 8'd2;   t2[2] = 8'hFD; t2[3] = 8'd4;
    t2[4] = 8'h80;  t2[5] = 8'h7F;  t2[6] = 8'h00; t2[7] = 8'hFF;

    // T1: reset held 3 clocks with a valid sample offered
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h55; hold_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", s_ready, 1);
    @(posedge clk);
    #1;

    // T2: single directed frame including -128 and 127
    for (int i = 0; i < 8; i++) send(t2[i]);
    idle(20);
    chk("t2_frame_cnt", frame_cnt, 1);

    // T3: 32 samples streamed
    for (int i = 0; i < 32; i++) send(8'($urandom));
    idle(40);
    chk("t3_frame_cnt", frame_cnt, 5);

    // T4: backpressure, 17th sample must wait for a bank
    hold_mode = 1;
    for (int i = 0; i < 16; i++) send(8'($urandom));
    s_valid = 1'b1;
    s_data  = 8'hA5;
    repeat (6) @(posedge clk);
    #1;
    hold_mode = 0;
    send(8'hA5);
    for (int i = 0; i < 3; i++) send(8'($urandom));
    idle(40);
    chk("t4_frame_cnt", frame_cnt, 7);

    // T5: reset in the middle of operation
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) send(8'd10 + 8'(i));
    idle(30);
    chk("t5_frame_cnt", frame_cnt, 1);

    // Random traffic with random stalls; the small instance wraps its counter
    hold_mode = 2;
    for (int i = 0; i < 128; i++) begin
      send(8'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    hold_mode = 0;
    w = 0;
    while ((exp_q.size() != 0 || countdown != 0) && w < 600) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("drain_pending_frames", exp_q.size(), 0);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
